// File: rtl/fault_qual_pkg.sv
// Shared types and constants for the fault input qualifier.
// Optional build macro: FAULT_QUAL_SYNC_EN (2-flop input synchronizer per channel).
package fault_qual_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } qual_state_t;

  localparam int FQ_ON_CYCLES  = 16;
  localparam int FQ_OFF_CYCLES = 4;

  // Counter width: enough to hold the larger threshold, plus one bit of headroom.
  function automatic int fq_cnt_w(input int on_cycles, input int off_cycles);
    int max_v;
    max_v = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(max_v) + 1;
  endfunction

  // First-fault index width, never narrower than one bit.
  function automatic int fq_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/fault_qual_ch.sv
// One fault channel: optional synchronizer, assert/release debounce FSM and run counter.
// Optional build macro: FAULT_QUAL_SYNC_EN adds a 2-flop synchronizer in front of the FSM.
module fault_qual_ch
  import fault_qual_pkg::*;
#(
  parameter int ON_CYCLES  = FQ_ON_CYCLES,
  parameter int OFF_CYCLES = FQ_OFF_CYCLES,
  parameter int CNT_W      = fq_cnt_w(FQ_ON_CYCLES, FQ_OFF_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic q,
  output logic rise
);

  logic             sample_s;
  qual_state_t      state_r;
  qual_state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             q_r;
  logic             q_nxt_s;

`ifdef FAULT_QUAL_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchronizer for the possibly asynchronous comparator input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = sync2_r;
`else
  assign sample_s = raw;
`endif

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and counter logic; a broken run always restarts from zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (sample_s) begin
          if (ON_CYCLES == 1) begin
            state_nxt_s = ACTIVE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ARMING;
            cnt_nxt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      ARMING: begin
        if (sample_s) begin
          if (cnt_inc_s == CNT_W'(ON_CYCLES)) begin
            state_nxt_s = ACTIVE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ARMING;
            cnt_nxt_s   = cnt_inc_s;
          end
        end else begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      ACTIVE: begin
        if (!sample_s) begin
          if (OFF_CYCLES == 1) begin
            state_nxt_s = CLEAR;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = RELEASING;
            cnt_nxt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = ACTIVE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      RELEASING: begin
        if (!sample_s) begin
          if (cnt_inc_s == CNT_W'(OFF_CYCLES)) begin
            state_nxt_s = CLEAR;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = RELEASING;
            cnt_nxt_s   = cnt_inc_s;
          end
        end else begin
          state_nxt_s = ACTIVE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_nxt_s = CLEAR;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign q_nxt_s = (state_nxt_s == ACTIVE) || (state_nxt_s == RELEASING);

  // State, counter and the registered qualified level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
      q_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      q_r     <= q_nxt_s;
    end
  end

  assign q    = q_r;
  // Rise flags the edge on which q is about to go 0->1, so capture lands on that same edge.
  assign rise = ~reset & q_nxt_s & ~q_r;

endmodule

// File: rtl/fault_qualifier.sv
// Fault input qualifier top: per-channel debounce, any-fault summary, first-fault capture.
// Optional build macro: FAULT_QUAL_SYNC_EN (2-flop synchronizer on every raw input).
module fault_qualifier
  import fault_qual_pkg::*;
#(
  parameter  int N_CH       = 8,
  parameter  int ON_CYCLES  = FQ_ON_CYCLES,
  parameter  int OFF_CYCLES = FQ_OFF_CYCLES,
  localparam int CNT_W      = fq_cnt_w(ON_CYCLES, OFF_CYCLES),
  localparam int IDX_W      = fq_idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  raw_in,
  input  logic             ff_clr,
  output logic [N_CH-1:0]  qual_out,
  output logic             any_fault,
  output logic             ff_valid,
  output logic [IDX_W-1:0] ff_idx
);

  logic [N_CH-1:0]  rise_s;
  logic [IDX_W-1:0] low_idx_s;
  logic             capture_s;
  logic             any_fault_r;
  logic             ff_valid_r;
  logic [IDX_W-1:0] ff_idx_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fault_qual_ch #(
      .ON_CYCLES  (ON_CYCLES),
      .OFF_CYCLES (OFF_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[g]),
      .q     (qual_out[g]),
      .rise  (rise_s[g])
    );
  end

  // Lowest-numbered channel rising on this edge wins the first-fault slot.
  always_comb begin
    low_idx_s = {IDX_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      low_idx_s = rise_s[i] ? IDX_W'(i) : low_idx_s;
    end
  end

  assign capture_s = (~ff_valid_r | ff_clr) & (|rise_s);

  // Summary flag, one cycle behind the qualified levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_fault_r <= 1'b0;
    end else begin
      any_fault_r <= |qual_out;
    end
  end

  // First-fault capture; a clear coinciding with a rise re-arms and captures at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_valid_r <= 1'b0;
      ff_idx_r   <= {IDX_W{1'b0}};
    end else if (capture_s) begin
      ff_valid_r <= 1'b1;
      ff_idx_r   <= low_idx_s;
    end else if (ff_clr) begin
      ff_valid_r <= 1'b0;
    end
  end

  assign any_fault = any_fault_r;
  assign ff_valid  = ff_valid_r;
  assign ff_idx    = ff_idx_r;

endmodule

// File: doc/fault_qualifier.md
Name: fault_qualifier

Overview:
- Upstream input-conditioning stage for the RPSC fault cards.
- Debounces N raw fault/alarm comparator inputs (U_CA_Low, I_CA_High, DC_PS_Low, …) with independent assert and release filters.
- Presents clean qualified levels to the fault flip-flop latches, plus a first-fault capture register for operator diagnostics.

Parameters:
- N_CH, 8, number of fault channels.
- ON_CYCLES, 16, consecutive high samples required to assert a qualified fault; must be ≥1.
- OFF_CYCLES, 4, consecutive low samples required to release a qualified fault; must be ≥1.
- CNT_W, $clog2(max(ON_CYCLES,OFF_CYCLES))+1, counter width (derived).
- IDX_W, $clog2(N_CH) (min 1), first-fault index width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  N_CH  raw fault inputs, bit i = channel i, active-high, may be asynchronous/noisy.
- ff_clr  in  1  single-cycle pulse; clears first-fault capture.
- qual_out  out  N_CH  debounced fault levels; feed FF latch "in" pins.
- any_fault  out  1  registered OR of qual_out.
- ff_valid  out  1  first-fault register holds a valid capture.
- ff_idx  out  IDX_W  index of the first channel to qualify.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All channel FSMs in CLEAR, counters 0.
  - qual_out=0, any_fault=0, ff_valid=0, ff_idx=0.
- Per-channel FSM, evaluated on each clk edge using sampled input s (raw_in[i], or the synchronized version when the optional feature is on):
  - CLEAR (q=0):
    - s=1 → cnt=1; if ON_CYCLES==1 go ACTIVE, else go ARMING.
    - s=0 → stay.
  - ARMING (q=0):
    - s=1 → cnt++; when cnt reaches ON_CYCLES go ACTIVE, cnt=0.
    - s=0 → CLEAR, cnt=0 (no partial credit).
  - ACTIVE (q=1):
    - s=0 → cnt=1; if OFF_CYCLES==1 go CLEAR, else go RELEASING.
    - s=1 → stay.
  - RELEASING (q=1):
    - s=0 → cnt++; when cnt reaches OFF_CYCLES go CLEAR, cnt=0.
    - s=1 → ACTIVE, cnt=0.
- Latency: qual_out[i] rises on the same edge that samples the ON_CYCLES-th consecutive high, and falls on the edge that samples the OFF_CYCLES-th consecutive low. qual_out is a registered state decode, glitch-free.
- Counters never exceed their thresholds and do not wrap.
- any_fault is registered one cycle after qual_out.
- First-fault capture:
  - rise[i] = qual_out[i] goes 0→1 on this edge.
  - Capture condition: ff_valid=0 (or ff_clr=1 this cycle) and rise≠0. Then ff_idx = lowest i with rise[i], and ff_valid=1.
  - ff_clr with no rise → ff_valid=0; ff_idx holds its last value.
  - ff_clr together with a rise → capture the new rise; ff_valid stays 1.
  - While ff_valid=1 and no ff_clr, later rises are ignored.
- Reset asserted mid-count returns every channel to CLEAR. Qualification restarts from zero after reset deasserts.

Optional Feature:
- Macro: FAULT_QUAL_SYNC_EN.
- Defined: each raw_in bit passes through a 2-flop synchronizer (reset to 0) before the FSM. Assert and release latency each grow by exactly 2 cycles.
- Undefined: raw_in is sampled directly. raw_in must then already be synchronous to clk.

Decomposition:
- Package fault_qual_pkg holds:
  - typedef enum logic [1:0] {CLEAR, ARMING, ACTIVE, RELEASING} qual_state_t;
  - default constants FQ_ON_CYCLES=16 and FQ_OFF_CYCLES=4.
  - a function computing the counter width.
- Sub-module fault_qual_ch: one channel's synchronizer, FSM and counter, with outputs q and rise. It is instantiated N_CH times by a generate loop.
- The top level holds only the first-fault logic and any_fault.

Test Plan (ON_CYCLES=16, OFF_CYCLES=4, N_CH=8, macro undefined unless stated):
1. raw_in[0]=1 held from edge 1 → qual_out[0]=1 after edge 16 (0 after edge 15); any_fault=1 after edge 17; ff_valid=1, ff_idx=0.
2. raw_in[2] high for 15 edges then low → qual_out[2] never asserts; ff_valid stays 0.
3. Channel 1 active, raw low for 3 edges then high → qual_out[1] stays 1. Raw low for 4 edges → qual_out[1]=0 after the 4th edge.
4. raw_in[3] and raw_in[5] rise together and hold → ff_idx=3 after edge 16. raw_in[1] qualifies later → ff_idx stays 3. Pulse ff_clr → ff_valid=0.
5. ff_clr pulsed on the exact edge channel 6 qualifies → ff_valid=1, ff_idx=6.
6. reset asserted after 10 high samples on channel 4 and released with raw still high → qual_out[4] asserts 16 edges after release. Rerun case 1 with FAULT_QUAL_SYNC_EN defined → assertion after edge 18.
